// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and is held until the owner acknowledges.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    input  logic             rack0,
    input  logic             rack1,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             illegal_op
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             lastOwner_q, lastOwner_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             illegal_q, illegal_d;
    logic             armed_q;
    logic             winner;
    logic             grantEn;

    // On a tie the requester that was not served last wins; a lone request always wins.
    assign winner  = (req0 && req1) ? ~lastOwner_q : req1;
    // armed_q keeps grants off between reset release and the first clock edge.
    assign grantEn = (state_q == IDLE) && armed_q && (req0 || req1);
    assign gnt0    = grantEn && !winner;
    assign gnt1    = grantEn && winner;

    assign alu_op  = (state_q == EXEC) ? op_q : 3'd3;
    assign alu_in1 = (state_q == EXEC) ? a_q : '0;
    assign alu_in2 = (state_q == EXEC) ? b_q : '0;

    assign busy       = (state_q != IDLE);
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign illegal_op = illegal_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        rvalid0_d   = rvalid0_q;
        rvalid1_d   = rvalid1_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (grantEn) begin
                    owner_d = winner;
                    op_d    = winner ? op1 : op0;
                    a_d     = winner ? a1 : a0;
                    b_d     = winner ? b1 : b0;
                    if (op_d[2:1] == 2'b11) begin
                        illegal_d = 1'b1;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rdata1_d  = alu_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = alu_out;
                    rvalid0_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rack1 : rack0) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                    rvalid0_d   = 1'b0;
                    rvalid1_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            illegal_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            illegal_q   <= illegal_d;
            armed_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural model of the shared ALU.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [2:0]       op0 = '0, op1 = '0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             rack0 = 1'b0, rack1 = 1'b0;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
    logic             busy, illegal_op;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    // Shared ALU: 0 pass, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6/7 produce zero.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'd0: alu_out = alu_in1;
            3'd1: alu_out = alu_in1 + alu_in2;
            3'd2: alu_out = alu_in1 - alu_in2;
            3'd3: alu_out = alu_in1 & alu_in2;
            3'd4: alu_out = alu_in1 | alu_in2;
            3'd5: alu_out = alu_in1 ^ alu_in2;
            default: alu_out = '0;
        endcase
    end

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rack0(rack0), .rack1(rack1),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .busy(busy), .illegal_op(illegal_op)
    );

    task automatic nextCycle;
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0 = 1'b1; op0 = 3'd1; a0 = 32'd1; b0 = 32'd1;
        @(negedge clock);
        #1;
        compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL reset_gnt0: got %0b want 0", gnt0); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
        compared++; if ({rvalid0, rvalid1} !== 2'b00) begin mismatched++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
        compared++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin mismatched++; $display("FAIL reset_rdata: got %0d/%0d want 0/0", rdata0, rdata1); end
        compared++; if (illegal_op !== 1'b0) begin mismatched++; $display("FAIL reset_illegal: got %0b want 0", illegal_op); end
        compared++; if (alu_op !== 3'd3 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin mismatched++; $display("FAIL reset_alu: got op=%0d in=%0d/%0d want 3 0/0", alu_op, alu_in1, alu_in2); end
        reset = 1'b0;
        #1;
        compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL release_gnt0: got %0b want 0 before first edge", gnt0); end
        req0 = 1'b0;
        nextCycle();
    endtask

    task automatic test_single_add;
        req0 = 1'b1; op0 = 3'd1; a0 = 32'd5; b0 = 32'd7;
        #1;
        compared++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL add_gnt: got %0b%0b want 10", gnt0, gnt1); end
        nextCycle();
        req0 = 1'b0; a0 = 32'd99;
        #1;
        compared++; if (alu_op !== 3'd1 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin mismatched++; $display("FAIL add_exec: got op=%0d in=%0d/%0d want 1 5/7", alu_op, alu_in1, alu_in2); end
        compared++; if (busy !== 1'b1 || rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin mismatched++; $display("FAIL add_exec_flags: got busy=%0b rvalid0=%0b gnt0=%0b want 1 0 0", busy, rvalid0, gnt0); end
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            compared++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd12) begin mismatched++; $display("FAIL add_resp%0d: got rvalid0=%0b rdata0=%0d want 1 12", i, rvalid0, rdata0); end
            compared++; if (alu_op !== 3'd3 || alu_in1 !== 32'd0) begin mismatched++; $display("FAIL add_alu_idle%0d: got op=%0d in1=%0d want 3 0", i, alu_op, alu_in1); end
        end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
        compared++; if (rvalid0 !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL add_ack: got rvalid0=%0b busy=%0b want 0 0", rvalid0, busy); end
    endtask

    task automatic test_tie;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        nextCycle();
        req0 = 1'b1; op0 = 3'd1; a0 = 32'd1;  b0 = 32'd2;
        req1 = 1'b1; op1 = 3'd2; a1 = 32'd20; b1 = 32'd5;
        #1;
        compared++; if ({gnt0, gnt1} !== 2'b10) begin mismatched++; $display("FAIL tie1_gnt: got %0b%0b want 10", gnt0, gnt1); end
        nextCycle();
        req0 = 1'b0;
        #1;
        compared++; if (gnt1 !== 1'b0) begin mismatched++; $display("FAIL tie_exec_gnt1: got %0b want 0", gnt1); end
        nextCycle();
        compared++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd3 || gnt1 !== 1'b0) begin mismatched++; $display("FAIL tie_resp0: got rvalid0=%0b rdata0=%0d gnt1=%0b want 1 3 0", rvalid0, rdata0, gnt1); end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
        #1;
        compared++; if ({gnt0, gnt1} !== 2'b01) begin mismatched++; $display("FAIL tie_second_gnt: got %0b%0b want 01", gnt0, gnt1); end
        nextCycle();
        req1 = 1'b0;
        nextCycle();
        compared++; if (rvalid1 !== 1'b1 || rdata1 !== 32'd15) begin mismatched++; $display("FAIL tie_resp1: got rvalid1=%0b rdata1=%0d want 1 15", rvalid1, rdata1); end
        compared++; if (rdata0 !== 32'd3 || rvalid0 !== 1'b0) begin mismatched++; $display("FAIL tie_other_hold: got rdata0=%0d rvalid0=%0b want 3 0", rdata0, rvalid0); end
        rack1 = 1'b1;
        nextCycle();
        rack1 = 1'b0;
        req0 = 1'b1; op0 = 3'd0; a0 = 32'd42; b0 = 32'd1;
        req1 = 1'b1;
        #1;
        compared++; if ({gnt0, gnt1} !== 2'b10) begin mismatched++; $display("FAIL tie3_gnt: got %0b%0b want 10", gnt0, gnt1); end
        nextCycle();
        req0 = 1'b0; req1 = 1'b0;
        #1;
        compared++; if (alu_op !== 3'd0 || alu_in1 !== 32'd42) begin mismatched++; $display("FAIL pass_exec: got op=%0d in1=%0d want 0 42", alu_op, alu_in1); end
        nextCycle();
        compared++; if (rdata0 !== 32'd42) begin mismatched++; $display("FAIL pass_resp: got %0d want 42", rdata0); end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
    endtask

    task automatic test_slow_ack;
        req1 = 1'b1; op1 = 3'd2; a1 = 32'd10; b1 = 32'd3;
        #1;
        compared++; if ({gnt0, gnt1} !== 2'b01) begin mismatched++; $display("FAIL slow_gnt1: got %0b%0b want 01", gnt0, gnt1); end
        nextCycle();
        req1 = 1'b0;
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req0 = 1'b1; op0 = 3'd1; a0 = 32'd1; b0 = 32'd1;
                #1;
            end
            compared++; if (rvalid1 !== 1'b1 || rdata1 !== 32'd7) begin mismatched++; $display("FAIL slow_hold%0d: got rvalid1=%0b rdata1=%0d want 1 7", i, rvalid1, rdata1); end
            compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL slow_wait%0d: got gnt0=%0b want 0", i, gnt0); end
            nextCycle();
        end
        rack1 = 1'b1;
        #1;
        compared++; if (gnt0 !== 1'b0 || rvalid1 !== 1'b1) begin mismatched++; $display("FAIL slow_ackcycle: got gnt0=%0b rvalid1=%0b want 0 1", gnt0, rvalid1); end
        nextCycle();
        rack1 = 1'b0;
        #1;
        compared++; if (gnt0 !== 1'b1 || rvalid1 !== 1'b0) begin mismatched++; $display("FAIL slow_after: got gnt0=%0b rvalid1=%0b want 1 0", gnt0, rvalid1); end
        nextCycle();
        req0 = 1'b0;
        nextCycle();
        compared++; if (rdata0 !== 32'd2) begin mismatched++; $display("FAIL slow_next: got rdata0=%0d want 2", rdata0); end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
    endtask

    task automatic test_illegal;
        req0 = 1'b1; op0 = 3'd6; a0 = 32'd9; b0 = 32'd9;
        #1;
        compared++; if (gnt0 !== 1'b1 || illegal_op !== 1'b0) begin mismatched++; $display("FAIL ill_gnt: got gnt0=%0b illegal=%0b want 1 0", gnt0, illegal_op); end
        nextCycle();
        req0 = 1'b0;
        compared++; if (alu_op !== 3'd6 || illegal_op !== 1'b1) begin mismatched++; $display("FAIL ill_exec: got op=%0d illegal=%0b want 6 1", alu_op, illegal_op); end
        nextCycle();
        compared++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd0) begin mismatched++; $display("FAIL ill_resp: got rvalid0=%0b rdata0=%0d want 1 0", rvalid0, rdata0); end
        rack1 = 1'b1;
        nextCycle();
        rack1 = 1'b0;
        compared++; if (rvalid0 !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("FAIL stray_rack1: got rvalid0=%0b busy=%0b want 1 1", rvalid0, busy); end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
        req0 = 1'b1; op0 = 3'd5; a0 = 32'hF0; b0 = 32'h3C;
        nextCycle();
        req0 = 1'b0;
        nextCycle();
        compared++; if (rdata0 !== 32'hCC || illegal_op !== 1'b1) begin mismatched++; $display("FAIL ill_sticky: got rdata0=%0h illegal=%0b want cc 1", rdata0, illegal_op); end
        rack0 = 1'b1;
        nextCycle();
        rack0 = 1'b0;
    endtask

    task automatic test_back_to_back;
        req0 = 1'b1; op0 = 3'd1; a0 = 32'd3; b0 = 32'd4;
        nextCycle();
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        compared++; if (busy !== 1'b0 || alu_op !== 3'd3 || alu_in1 !== 32'd0 || gnt0 !== 1'b0) begin mismatched++; $display("FAIL mid_reset: got busy=%0b op=%0d in1=%0d gnt0=%0b want 0 3 0 0", busy, alu_op, alu_in1, gnt0); end
        compared++; if (rvalid0 !== 1'b0 || rdata0 !== 32'd0 || illegal_op !== 1'b0) begin mismatched++; $display("FAIL mid_reset_regs: got rvalid0=%0b rdata0=%0d illegal=%0b want 0 0 0", rvalid0, rdata0, illegal_op); end
        nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            compared++; if (rvalid0 !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL post_reset%0d: got rvalid0=%0b busy=%0b want 0 0", i, rvalid0, busy); end
        end
        req0 = 1'b1; op0 = 3'd1; a0 = 32'd100; b0 = 32'd1;
        req1 = 1'b1; op1 = 3'd2; a1 = 32'd100; b1 = 32'd1;
        rack0 = 1'b1; rack1 = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            logic eg0, eg1, ev0, ev1;
            eg0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
            eg1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
            ev0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
            ev1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
            compared++; if ({gnt0, gnt1} !== {eg0, eg1}) begin mismatched++; $display("FAIL b2b_gnt c%0d: got %0b%0b want %0b%0b", c, gnt0, gnt1, eg0, eg1); end
            compared++; if ({rvalid0, rvalid1} !== {ev0, ev1}) begin mismatched++; $display("FAIL b2b_rvalid c%0d: got %0b%0b want %0b%0b", c, rvalid0, rvalid1, ev0, ev1); end
            if (ev0) begin
                compared++; if (rdata0 !== 32'd101) begin mismatched++; $display("FAIL b2b_rdata0 c%0d: got %0d want 101", c, rdata0); end
            end
            if (ev1) begin
                compared++; if (rdata1 !== 32'd99) begin mismatched++; $display("FAIL b2b_rdata1 c%0d: got %0d want 99", c, rdata1); end
            end
            nextCycle();
        end
        req0 = 1'b0; req1 = 1'b0; rack0 = 1'b0; rack1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_slow_ack();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
